// File: rtl/fusion_core_pkg.sv
// Shared core definitions: datapath width, register address width and
// the writeback kind encoding used by the ALU result path.
package fusion_core_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_FULL     = 2'b00,
    WB_LI_UPPER = 2'b01,
    WB_LI_LOWER = 2'b10
  } wb_kind_t;
endpackage

// File: rtl/fusion_wb_fifo.sv
// Synchronous FIFO holding returning load results; head is visible
// combinationally, pushes beyond full and pops from empty are ignored.
module fusion_wb_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/fusion_writeback_unit.sv
// Register-file writeback driver: arbitrates ALU results against queued
// loads with bounded starvation and registers one write per cycle.
module fusion_writeback_unit
  import fusion_core_pkg::*;
#(
  parameter int unsigned XLEN         = fusion_core_pkg::XLEN,
  parameter int unsigned LD_DEPTH     = 2,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                         clk_in,
  input  logic                         reset_in,
  input  logic                         alu_valid_in,
  output logic                         alu_ready_out,
  input  logic [REG_ADDR_W-1:0]        alu_rd_in,
  input  logic [XLEN-1:0]              alu_val_in,
  input  logic [1:0]                   alu_kind_in,
  input  logic                         ld_valid_in,
  output logic                         ld_ready_out,
  input  logic [REG_ADDR_W-1:0]        ld_rd_in,
  input  logic [XLEN-1:0]              ld_val_in,
  output logic [XLEN-1:0]              rd_val_out,
  output logic [16:0]                  rd_half_out,
  output logic [REG_ADDR_W-1:0]        rd_out,
  output logic                         wb_out,
  output logic                         wb_half_out,
  output logic                         wb_u_nl_out,
  output logic                         byp_valid_out,
  output logic [REG_ADDR_W-1:0]        byp_rd_out,
  output logic [XLEN-1:0]              byp_val_out,
  output logic [$clog2(LD_DEPTH):0]    ld_count_out
);
  localparam int unsigned EW = REG_ADDR_W + XLEN;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [EW-1:0]         w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_force;
  logic                  w_alu_win;
  logic                  w_ld_win;
  logic [REG_ADDR_W-1:0] w_sel_rd;
  logic [XLEN-1:0]       w_sel_val;
  logic                  w_half;
  logic                  w_u_nl;
  logic [XLEN-1:0]       w_wval;

  logic [SW-1:0]         r_starve;
  logic                  r_wb;
  logic                  r_half;
  logic                  r_u_nl;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_val;
  logic [16:0]           r_half_val;

  fusion_wb_fifo #(
    .WIDTH (EW),
    .DEPTH (LD_DEPTH)
  ) u_ld_fifo (
    .i_clk       (clk_in),
    .i_rst_n     (reset_in),
    .i_push      (w_push),
    .i_push_data ({ld_rd_in, ld_val_in}),
    .i_pop       (w_ld_win),
    .o_head      (w_head),
    .o_count     (ld_count_out),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign ld_ready_out  = !w_full;
  assign w_push        = ld_valid_in && ld_ready_out;
  assign w_force       = !w_empty && (r_starve == SW'(STARVE_LIMIT));
  assign alu_ready_out = !w_force;
  assign w_alu_win     = !w_force && alu_valid_in;
  assign w_ld_win      = w_force || (!alu_valid_in && !w_empty);

  always_comb begin
    w_sel_rd  = w_head[EW-1:XLEN];
    w_sel_val = w_head[XLEN-1:0];
    w_half    = 1'b0;
    w_u_nl    = 1'b0;
    if (w_alu_win) begin
      w_sel_rd  = alu_rd_in;
      w_sel_val = alu_val_in;
      if (alu_kind_in == WB_LI_UPPER) begin
        w_half = 1'b1;
        w_u_nl = 1'b1;
      end else if (alu_kind_in == WB_LI_LOWER) begin
        w_half = 1'b1;
      end
    end
    // Half writes expose the 16-bit immediate placed in its half, other half zero.
    w_wval = w_sel_val;
    if (w_half) begin
      w_wval = w_u_nl ? (XLEN'(w_sel_val[15:0]) << (XLEN/2))
                      : XLEN'(w_sel_val[15:0]);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      r_starve <= '0;
    end else if (!w_empty && w_alu_win) begin
      if (r_starve != SW'(STARVE_LIMIT)) r_starve <= r_starve + 1'b1;
    end else begin
      r_starve <= '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      r_wb       <= 1'b0;
      r_half     <= 1'b0;
      r_u_nl     <= 1'b0;
      r_rd       <= '0;
      r_val      <= '0;
      r_half_val <= '0;
    end else begin
      r_wb <= 1'b0;
      if (w_alu_win || w_ld_win) begin
        r_wb       <= (w_sel_rd != '0);
        r_rd       <= w_sel_rd;
        r_half     <= w_half;
        r_u_nl     <= w_u_nl;
        r_val      <= w_wval;
        r_half_val <= {1'b0, w_sel_val[15:0]};
      end
    end
  end

  assign wb_out        = r_wb;
  assign rd_out        = r_rd;
  assign rd_val_out    = r_val;
  assign rd_half_out   = r_half_val;
  assign wb_half_out   = r_half;
  assign wb_u_nl_out   = r_u_nl;
  assign byp_valid_out = r_wb;
  assign byp_rd_out    = r_rd;
  assign byp_val_out   = r_val;
endmodule

// File: tb/tb_fusion_writeback_unit.sv
// Directed bench: stimulus pushes hand-computed writes into a queue, a
// negedge monitor pops and checks each register write the unit issues.
module tb_fusion_writeback_unit;
  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        alu_valid_in;
  logic        alu_ready_out;
  logic [4:0]  alu_rd_in;
  logic [31:0] alu_val_in;
  logic [1:0]  alu_kind_in;
  logic        ld_valid_in;
  logic        ld_ready_out;
  logic [4:0]  ld_rd_in;
  logic [31:0] ld_val_in;
  logic [31:0] rd_val_out;
  logic [16:0] rd_half_out;
  logic [4:0]  rd_out;
  logic        wb_out;
  logic        wb_half_out;
  logic        wb_u_nl_out;
  logic        byp_valid_out;
  logic [4:0]  byp_rd_out;
  logic [31:0] byp_val_out;
  logic [1:0]  ld_count_out;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    logic        half;
    logic        u_nl;
    logic [16:0] hv;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic mon_en  = 1'b0;

  fusion_writeback_unit #(
    .XLEN         (32),
    .LD_DEPTH     (2),
    .STARVE_LIMIT (3)
  ) dut (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .alu_valid_in  (alu_valid_in),
    .alu_ready_out (alu_ready_out),
    .alu_rd_in     (alu_rd_in),
    .alu_val_in    (alu_val_in),
    .alu_kind_in   (alu_kind_in),
    .ld_valid_in   (ld_valid_in),
    .ld_ready_out  (ld_ready_out),
    .ld_rd_in      (ld_rd_in),
    .ld_val_in     (ld_val_in),
    .rd_val_out    (rd_val_out),
    .rd_half_out   (rd_half_out),
    .rd_out        (rd_out),
    .wb_out        (wb_out),
    .wb_half_out   (wb_half_out),
    .wb_u_nl_out   (wb_u_nl_out),
    .byp_valid_out (byp_valid_out),
    .byp_rd_out    (byp_rd_out),
    .byp_val_out   (byp_val_out),
    .ld_count_out  (ld_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] val,
                          input logic half, input logic u_nl, input logic [16:0] hv);
    exp_t e;
    e.rd = rd; e.val = val; e.half = half; e.u_nl = u_nl; e.hv = hv;
    q.push_back(e);
  endtask

  // Inputs change 1 time unit after the edge; ready checks follow at +2.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] aval,
                      input logic [1:0] kind, input logic lv, input logic [4:0] lrd,
                      input logic [31:0] lval);
    @(posedge clk_in);
    #1;
    alu_valid_in = av; alu_rd_in = ard; alu_val_in = aval; alu_kind_in = kind;
    ld_valid_in  = lv; ld_rd_in  = lrd; ld_val_in  = lval;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 2'b00, 1'b0, 5'd0, 32'd0);
  endtask

  always @(negedge clk_in) begin
    if (mon_en) begin
      chk("byp_valid_eq_wb", {63'd0, byp_valid_out}, {63'd0, wb_out});
      if (wb_out === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_write_rd", {59'd0, rd_out}, 64'hFFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("wr_rd", {59'd0, rd_out}, {59'd0, e.rd});
          chk("wr_byp_rd", {59'd0, byp_rd_out}, {59'd0, e.rd});
          chk("wr_half", {63'd0, wb_half_out}, {63'd0, e.half});
          chk("wr_byp_val", {32'd0, byp_val_out}, {32'd0, e.val});
          if (e.half) begin
            chk("wr_u_nl", {63'd0, wb_u_nl_out}, {63'd0, e.u_nl});
            chk("wr_half_val", {47'd0, rd_half_out}, {47'd0, e.hv});
          end else begin
            chk("wr_val", {32'd0, rd_val_out}, {32'd0, e.val});
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_in = 1'b0;
    alu_valid_in = 1'b0; alu_rd_in = '0; alu_val_in = '0; alu_kind_in = '0;
    ld_valid_in = 1'b0;  ld_rd_in = '0;  ld_val_in = '0;

    // Reset state after two reset cycles
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_wb", {63'd0, wb_out}, 64'd0);
    chk("rst_byp_valid", {63'd0, byp_valid_out}, 64'd0);
    chk("rst_rd", {59'd0, rd_out}, 64'd0);
    chk("rst_val", {32'd0, rd_val_out}, 64'd0);
    chk("rst_half_val", {47'd0, rd_half_out}, 64'd0);
    chk("rst_half", {62'd0, wb_half_out, wb_u_nl_out}, 64'd0);
    chk("rst_byp", {27'd0, byp_rd_out, byp_val_out}, 64'd0);
    chk("rst_count", {62'd0, ld_count_out}, 64'd0);
    chk("rst_ld_ready", {63'd0, ld_ready_out}, 64'd1);
    chk("rst_alu_ready", {63'd0, alu_ready_out}, 64'd1);
    mon_en = 1'b1;
    @(posedge clk_in);
    #1 reset_in = 1'b1;
    idle(3);

    // ALU full write, LI halves, reserved kind treated as full
    step(1'b1, 5'd5, 32'hDEADBEEF, 2'b00, 1'b0, 5'd0, 32'd0);
    chk("alu_ready_full", {63'd0, alu_ready_out}, 64'd1);
    push_exp(5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 17'h0);
    step(1'b1, 5'd3, 32'h0000_1234, 2'b01, 1'b0, 5'd0, 32'd0);
    push_exp(5'd3, 32'h1234_0000, 1'b1, 1'b1, 17'h01234);
    step(1'b1, 5'd3, 32'h0000_ABCD, 2'b10, 1'b0, 5'd0, 32'd0);
    push_exp(5'd3, 32'h0000_ABCD, 1'b1, 1'b0, 17'h0ABCD);
    step(1'b1, 5'd4, 32'hCAFE_F00D, 2'b11, 1'b0, 5'd0, 32'd0);
    push_exp(5'd4, 32'hCAFE_F00D, 1'b0, 1'b0, 17'h0);
    idle(2);

    // Starvation: load pushed while ALU is always valid
    step(1'b1, 5'd10, 32'h100, 2'b00, 1'b1, 5'd7, 32'h11);
    chk("stv_ld_ready", {63'd0, ld_ready_out}, 64'd1);
    push_exp(5'd10, 32'h100, 1'b0, 1'b0, 17'h0);
    step(1'b1, 5'd10, 32'h101, 2'b00, 1'b0, 5'd0, 32'd0);
    chk("stv_count1", {62'd0, ld_count_out}, 64'd1);
    push_exp(5'd10, 32'h101, 1'b0, 1'b0, 17'h0);
    step(1'b1, 5'd10, 32'h102, 2'b00, 1'b0, 5'd0, 32'd0);
    push_exp(5'd10, 32'h102, 1'b0, 1'b0, 17'h0);
    step(1'b1, 5'd10, 32'h103, 2'b00, 1'b0, 5'd0, 32'd0);
    chk("stv_alu_ready_3rd", {63'd0, alu_ready_out}, 64'd1);
    push_exp(5'd10, 32'h103, 1'b0, 1'b0, 17'h0);
    step(1'b1, 5'd10, 32'h104, 2'b00, 1'b0, 5'd0, 32'd0);
    chk("stv_force", {63'd0, alu_ready_out}, 64'd0);
    push_exp(5'd7, 32'h11, 1'b0, 1'b0, 17'h0);
    step(1'b1, 5'd10, 32'h104, 2'b00, 1'b0, 5'd0, 32'd0);
    chk("stv_resume", {63'd0, alu_ready_out}, 64'd1);
    push_exp(5'd10, 32'h104, 1'b0, 1'b0, 17'h0);
    idle(2);

    // FIFO full and backpressure, drain order
    step(1'b1, 5'd20, 32'h200, 2'b00, 1'b1, 5'd8, 32'h88);
    push_exp(5'd20, 32'h200, 1'b0, 1'b0, 17'h0);
    step(1'b1, 5'd20, 32'h201, 2'b00, 1'b1, 5'd9, 32'h99);
    chk("full_ld_ready_1", {63'd0, ld_ready_out}, 64'd1);
    push_exp(5'd20, 32'h201, 1'b0, 1'b0, 17'h0);
    step(1'b1, 5'd20, 32'h202, 2'b00, 1'b1, 5'd30, 32'h333);
    chk("full_count2", {62'd0, ld_count_out}, 64'd2);
    chk("full_ld_ready_0", {63'd0, ld_ready_out}, 64'd0);
    push_exp(5'd20, 32'h202, 1'b0, 1'b0, 17'h0);
    step(1'b1, 5'd20, 32'h203, 2'b00, 1'b1, 5'd30, 32'h333);
    push_exp(5'd20, 32'h203, 1'b0, 1'b0, 17'h0);
    step(1'b1, 5'd20, 32'h204, 2'b00, 1'b1, 5'd30, 32'h333);
    chk("full_force", {63'd0, alu_ready_out}, 64'd0);
    chk("full_ld_ready_force", {63'd0, ld_ready_out}, 64'd0);
    push_exp(5'd8, 32'h88, 1'b0, 1'b0, 17'h0);
    step(1'b0, 5'd0, 32'd0, 2'b00, 1'b0, 5'd0, 32'd0);
    chk("drain_count1", {62'd0, ld_count_out}, 64'd1);
    push_exp(5'd9, 32'h99, 1'b0, 1'b0, 17'h0);
    idle(1);
    chk("drain_count0", {62'd0, ld_count_out}, 64'd0);
    idle(1);

    // r0 destination: consumed but never written
    step(1'b1, 5'd0, 32'h555, 2'b00, 1'b0, 5'd0, 32'd0);
    chk("r0_alu_ready", {63'd0, alu_ready_out}, 64'd1);
    idle(1);
    chk("r0_rd_out", {59'd0, rd_out}, 64'd0);
    chk("r0_wb", {62'd0, wb_out, byp_valid_out}, 64'd0);
    idle(1);

    // Mid-stream reset with two loads queued
    step(1'b1, 5'd21, 32'h300, 2'b00, 1'b1, 5'd11, 32'hB1);
    push_exp(5'd21, 32'h300, 1'b0, 1'b0, 17'h0);
    step(1'b1, 5'd21, 32'h301, 2'b00, 1'b1, 5'd12, 32'hB2);
    push_exp(5'd21, 32'h301, 1'b0, 1'b0, 17'h0);
    step(1'b0, 5'd0, 32'd0, 2'b00, 1'b0, 5'd0, 32'd0);
    chk("mrst_count2", {62'd0, ld_count_out}, 64'd2);
    reset_in = 1'b0;
    @(posedge clk_in);
    #1;
    chk("mrst_count0", {62'd0, ld_count_out}, 64'd0);
    chk("mrst_wb", {63'd0, wb_out}, 64'd0);
    chk("mrst_ld_ready", {63'd0, ld_ready_out}, 64'd1);
    reset_in = 1'b1;
    idle(6);

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fusion_writeback_unit.md
Name: fusion_writeback_unit

Overview:
- Write-side driver of the core register file: sole owner of the register file's writeback port (value, half value, destination, write strobe, upper/lower select).
- Merges two result sources: single-cycle ALU/LI results, and load results returning from the memory stage through a small FIFO.
- Issues at most one register write per cycle, with a bounded-starvation arbiter.
- Exports a bypass copy of the write in flight for decode-stage forwarding.

Parameters:
- XLEN, 32, datapath width.
- LD_DEPTH, 2, load FIFO entries (power of 2, ≥2).
- STARVE_LIMIT, 3, consecutive cycles a non-empty load FIFO may lose arbitration before it is forced to win.

Ports:
- clk_in  in  1  core clock.
- reset_in  in  1  synchronous, active-low reset.
- alu_valid_in  in  1  ALU result valid.
- alu_ready_out  out  1  ALU result accepted this cycle.
- alu_rd_in  in  5  ALU destination register.
- alu_val_in  in  XLEN  ALU result.
- alu_kind_in  in  2  00 full, 01 LI upper half, 10 LI lower half, 11 reserved (treated as full).
- ld_valid_in  in  1  load result valid.
- ld_ready_out  out  1  load FIFO not full.
- ld_rd_in  in  5  load destination register.
- ld_val_in  in  XLEN  load data.
- rd_val_out  out  XLEN  to register file full write value.
- rd_half_out  out  17  to register file half value; bit16 = 0, bits[15:0] = source value [15:0].
- rd_out  out  5  write destination.
- wb_out  out  1  write strobe.
- wb_half_out  out  1  half-word write.
- wb_u_nl_out  out  1  1 = upper half, 0 = lower half; meaningful only when wb_half_out = 1.
- byp_valid_out  out  1  bypass valid; equals wb_out.
- byp_rd_out  out  5  bypass destination.
- byp_val_out  out  XLEN  bypass value, equal to the value being written.
- ld_count_out  out  $clog2(LD_DEPTH)+1  FIFO occupancy, for debug/perf.

Behaviour:
- Reset:
  - On the clk_in edge with reset_in = 0, all outputs are 0 except ld_ready_out = 1 and alu_ready_out = 1.
  - FIFO is emptied (pointers 0) and the starvation counter is 0.
  - Reset asserted mid-stream drops all queued loads and the pending write; wb_out is 0 the following cycle.
- Load FIFO:
  - Push when ld_valid_in && ld_ready_out.
  - ld_ready_out = (count < LD_DEPTH); it is combinational from registered count, with no dependence on ld_valid_in.
  - Push and pop in the same cycle while full is illegal: ld_ready_out is already 0, so no push occurs.
  - Push and pop in the same cycle when not full: count is unchanged.
  - Pointers wrap modulo LD_DEPTH.
- Arbitration, evaluated each cycle:
  - force = (count != 0) && (starve_cnt == STARVE_LIMIT).
  - If force: the FIFO head wins and alu_ready_out = 0.
  - Else if alu_valid_in: the ALU wins and alu_ready_out = 1.
  - Else if count != 0: the FIFO head wins.
  - alu_ready_out = !force, independent of alu_valid_in.
  - starve_cnt increments (saturating at STARVE_LIMIT) when count != 0 and the ALU wins.
  - starve_cnt clears when the FIFO wins or count == 0.
- Write register stage: the winner's fields are registered, giving one-cycle latency from accept to wb_out.
  - Full (ALU kind 00/11, or any load): rd_val_out = value, wb_half_out = 0.
  - LI upper: wb_half_out = 1, wb_u_nl_out = 1, rd_half_out = {1'b0, val[15:0]}.
  - LI lower: wb_half_out = 1, wb_u_nl_out = 0, rd_half_out = {1'b0, val[15:0]}.
  - byp_val_out for a half write is the 16-bit value zero-extended into the selected half, with the other half 0. Consumers use byp_valid_out only when wb_half_out = 0.
- r0:
  - A winner with destination 0 is consumed (ready/pop as normal) but produces wb_out = 0 and byp_valid_out = 0 next cycle.
  - rd_out still reflects 0.
- No winner: wb_out = 0 next cycle. Data outputs hold their previous values.
- Ordering: loads retire in FIFO order. No ordering is enforced between ALU and load results; the hazard unit is responsible for that.

Decomposition:
- Shared package fusion_core_pkg holds:
  - XLEN.
  - REG_ADDR_W = 5.
  - The wb_kind_t encoding (WB_FULL = 2'b00, WB_LI_UPPER = 2'b01, WB_LI_LOWER = 2'b10).
- One sub-module, fusion_wb_fifo: parameterised sync FIFO (width 5+XLEN, depth LD_DEPTH) with push/pop/count/full/empty.

Test Plan:
- Reset then idle: reset_in low 2 cycles → all outputs 0, ld_ready_out = 1, alu_ready_out = 1; release, no valids → wb_out stays 0.
- ALU full write: alu rd = 5, val = 32'hDEADBEEF, kind 00 for 1 cycle → next cycle wb_out = 1, rd_out = 5, rd_val_out = DEADBEEF, wb_half_out = 0, byp_valid_out = 1.
- LI halves: kind 01, rd = 3, val = 32'h0000_1234, then kind 10, val = 32'h0000_ABCD → successive cycles wb_half_out = 1 with wb_u_nl_out = 1 / half = 0x1234, then wb_u_nl_out = 0 / half = 0xABCD.
- Starvation: one load (rd = 7, val = 0x11) pushed while ALU is valid every cycle, STARVE_LIMIT = 3 → ALU wins 3 cycles, 4th cycle alu_ready_out = 0 and the load writes rd = 7, val = 0x11 one cycle later; ALU resumes the next cycle.
- FIFO full/backpressure: push 2 loads while ALU is continuously valid → ld_ready_out = 0 with count = 2; third ld_valid_in is not accepted; drain order is preserved (rd 8 then rd 9).
- r0 and mid-stream reset: ALU rd = 0 → alu_ready_out = 1, wb_out = 0. With 2 loads queued, assert reset_in → ld_count_out = 0, wb_out = 0, and no queued load is ever written afterwards.
